// File: rtl/lnrv_wbck.sv
// ---------------------------------------------------------------------------
// lnrv_wbck - write-back arbiter and output stage in front of the GPR file
//
// Collects results from three producers (EXU, LSU, MDU), grants one per
// cycle, and holds it in a one-entry output register that drives the
// register file write handshake. Results addressed to x0 are accepted from
// the producer but never written.
//
// Optional feature macro: LNRV_WBCK_FWD_EN
//   defined   : fwd_rs1_hit/fwd_rs2_hit/fwd_data expose the pending entry
//   undefined : forwarding outputs are tied to 0 (ports kept identical)
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   exu_wbck_vld/rdy/idx/data    EXU result channel (vld/rdy handshake)
//   lsu_wbck_vld/rdy/idx/data    LSU result channel
//   mdu_wbck_vld/rdy/idx/data    MDU result channel
//   wr_vld/rdy/idx/data          register file write port
//   rs1_idx, rs2_idx             decode read indices for forwarding lookup
//   fwd_rs1_hit, fwd_rs2_hit     pending entry matches rsN_idx
//   fwd_data                     data of the pending entry
// ---------------------------------------------------------------------------
module lnrv_wbck #(
  parameter int P_STARVE_LIMIT = 4,
  parameter int P_DATA_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    exu_wbck_vld,
  output logic                    exu_wbck_rdy,
  input  logic [4:0]              exu_wbck_idx,
  input  logic [P_DATA_WIDTH-1:0] exu_wbck_data,
  input  logic                    lsu_wbck_vld,
  output logic                    lsu_wbck_rdy,
  input  logic [4:0]              lsu_wbck_idx,
  input  logic [P_DATA_WIDTH-1:0] lsu_wbck_data,
  input  logic                    mdu_wbck_vld,
  output logic                    mdu_wbck_rdy,
  input  logic [4:0]              mdu_wbck_idx,
  input  logic [P_DATA_WIDTH-1:0] mdu_wbck_data,
  output logic                    wr_vld,
  input  logic                    wr_rdy,
  output logic [4:0]              wr_idx,
  output logic [P_DATA_WIDTH-1:0] wr_data,
  input  logic [4:0]              rs1_idx,
  input  logic [4:0]              rs2_idx,
  output logic                    fwd_rs1_hit,
  output logic                    fwd_rs2_hit,
  output logic [P_DATA_WIDTH-1:0] fwd_data
);

  localparam logic [3:0] STARVE_LIMIT = 4'(P_STARVE_LIMIT);

  logic                    occ;
  logic [3:0]              starve_cnt;
  logic                    load_ok;
  logic                    exu_pri;
  logic                    exu_gnt;
  logic                    lsu_gnt;
  logic                    mdu_gnt;
  logic                    any_gnt;
  logic [4:0]              sel_idx;
  logic [P_DATA_WIDTH-1:0] sel_data;

  // The output register may take a new entry when it is empty or is being
  // drained this cycle, which gives one write per cycle without bubbles.
  // EXU is normally lowest priority; once it has been blocked for
  // STARVE_LIMIT cycles it jumps to the front for one grant.
  always_comb begin
    load_ok  = ~occ | wr_rdy;
    exu_pri  = (STARVE_LIMIT != 4'd0) && (starve_cnt == STARVE_LIMIT);
    exu_gnt  = 1'b0;
    lsu_gnt  = 1'b0;
    mdu_gnt  = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    if (load_ok) begin
      if (exu_pri && exu_wbck_vld) begin
        exu_gnt = 1'b1;
      end else if (lsu_wbck_vld) begin
        lsu_gnt = 1'b1;
      end else if (mdu_wbck_vld) begin
        mdu_gnt = 1'b1;
      end else if (exu_wbck_vld) begin
        exu_gnt = 1'b1;
      end
    end
    if (exu_gnt) begin
      sel_idx  = exu_wbck_idx;
      sel_data = exu_wbck_data;
    end else if (lsu_gnt) begin
      sel_idx  = lsu_wbck_idx;
      sel_data = lsu_wbck_data;
    end else if (mdu_gnt) begin
      sel_idx  = mdu_wbck_idx;
      sel_data = mdu_wbck_data;
    end
    any_gnt = exu_gnt | lsu_gnt | mdu_gnt;
  end

  assign exu_wbck_rdy = exu_gnt;
  assign lsu_wbck_rdy = lsu_gnt;
  assign mdu_wbck_rdy = mdu_gnt;

  // Output stage. A grant only happens when load_ok, so an x0 result that is
  // absorbed can only coincide with an empty stage or a draining one; in both
  // cases the stage ends up empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ     <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else if (any_gnt && (sel_idx != 5'd0)) begin
      occ     <= 1'b1;
      wr_idx  <= sel_idx;
      wr_data <= sel_data;
    end else if (occ && wr_rdy) begin
      occ     <= 1'b0;
    end
  end

  assign wr_vld = occ;

  // Counts cycles in which EXU is waiting but loses arbitration; saturates
  // at the limit so promotion holds until EXU is actually granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (exu_wbck_vld && !exu_gnt) begin
      if (starve_cnt != STARVE_LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

`ifdef LNRV_WBCK_FWD_EN
  // x0 never hits: it is hardwired to zero in the register file.
  assign fwd_rs1_hit = occ && (wr_idx == rs1_idx) && (rs1_idx != 5'd0);
  assign fwd_rs2_hit = occ && (wr_idx == rs2_idx) && (rs2_idx != 5'd0);
  assign fwd_data    = wr_data;
`else
  logic unused_rs;
  assign unused_rs   = ^{rs1_idx, rs2_idx};
  assign fwd_rs1_hit = 1'b0;
  assign fwd_rs2_hit = 1'b0;
  assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_lnrv_wbck.sv
// ---------------------------------------------------------------------------
// tb_lnrv_wbck - self-checking bench for lnrv_wbck
//
// Directed vectors drive the three producer channels; every result expected
// to reach the register file is pushed into a scoreboard queue at issue time
// and a separate monitor pops and compares on each write handshake.
// Handshake, hold, starvation, x0, forwarding and reset behaviour are
// compared directly. Honours LNRV_WBCK_FWD_EN for the forwarding expectations.
// ---------------------------------------------------------------------------
module tb_lnrv_wbck;

  logic        clk;
  logic        reset_n;
  logic        exu_wbck_vld, lsu_wbck_vld, mdu_wbck_vld;
  logic        exu_wbck_rdy, lsu_wbck_rdy, mdu_wbck_rdy;
  logic [4:0]  exu_wbck_idx, lsu_wbck_idx, mdu_wbck_idx;
  logic [31:0] exu_wbck_data, lsu_wbck_data, mdu_wbck_data;
  logic        wr_vld, wr_rdy;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_data;

`ifdef LNRV_WBCK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  lnrv_wbck #(.P_STARVE_LIMIT(4), .P_DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .exu_wbck_vld(exu_wbck_vld), .exu_wbck_rdy(exu_wbck_rdy),
    .exu_wbck_idx(exu_wbck_idx), .exu_wbck_data(exu_wbck_data),
    .lsu_wbck_vld(lsu_wbck_vld), .lsu_wbck_rdy(lsu_wbck_rdy),
    .lsu_wbck_idx(lsu_wbck_idx), .lsu_wbck_data(lsu_wbck_data),
    .mdu_wbck_vld(mdu_wbck_vld), .mdu_wbck_rdy(mdu_wbck_rdy),
    .mdu_wbck_idx(mdu_wbck_idx), .mdu_wbck_data(mdu_wbck_data),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_idx(wr_idx), .wr_data(wr_data),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .fwd_data(fwd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // ch: 0 = EXU, 1 = LSU, 2 = MDU
  task automatic applyStimulus(input int ch, input logic v,
                               input logic [4:0] idx, input logic [31:0] d);
    case (ch)
      0: begin exu_wbck_vld = v; exu_wbck_idx = idx; exu_wbck_data = d; end
      1: begin lsu_wbck_vld = v; lsu_wbck_idx = idx; lsu_wbck_data = d; end
      default: begin mdu_wbck_vld = v; mdu_wbck_idx = idx; mdu_wbck_data = d; end
    endcase
  endtask

  task automatic push_exp(input logic [4:0] idx, input logic [31:0] d);
    wr_t e;
    e.idx  = idx;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: each write handshake must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && wr_vld && wr_rdy) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write_idx", {27'd0, wr_idx}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("sb_wr_idx", {27'd0, wr_idx}, {27'd0, e.idx});
        checkOutput("sb_wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    wr_rdy  = 1'b1;
    rs1_idx = 5'd0;
    rs2_idx = 5'd0;
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1, 1'b0, 5'd0, 32'd0);
    applyStimulus(2, 1'b0, 5'd0, 32'd0);

    // Reset state
    #12;
    checkOutput("rst_wr_vld", 32'(wr_vld), 32'd0);
    checkOutput("rst_wr_idx", {27'd0, wr_idx}, 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_fwd_rs1_hit", 32'(fwd_rs1_hit), 32'd0);
    checkOutput("rst_fwd_data", fwd_data, 32'd0);
    reset_n = 1'b1;
    cyc();

    // EXU alone: accepted cycle 0, written cycle 1, empty cycle 2
    applyStimulus(0, 1'b1, 5'd5, 32'h11);
    push_exp(5'd5, 32'h11);
    smp();
    checkOutput("t1_exu_rdy", 32'(exu_wbck_rdy), 32'd1);
    cyc();
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    smp();
    checkOutput("t1_wr_vld", 32'(wr_vld), 32'd1);
    checkOutput("t1_wr_idx", {27'd0, wr_idx}, 32'd5);
    checkOutput("t1_wr_data", wr_data, 32'h11);
    cyc();
    smp();
    checkOutput("t1_wr_vld_empty", 32'(wr_vld), 32'd0);
    cyc();

    // LSU beats EXU, EXU follows next cycle
    applyStimulus(1, 1'b1, 5'd3, 32'hAA);
    applyStimulus(0, 1'b1, 5'd4, 32'hBB);
    push_exp(5'd3, 32'hAA);
    push_exp(5'd4, 32'hBB);
    smp();
    checkOutput("t2_lsu_rdy", 32'(lsu_wbck_rdy), 32'd1);
    checkOutput("t2_exu_rdy_blocked", 32'(exu_wbck_rdy), 32'd0);
    cyc();
    applyStimulus(1, 1'b0, 5'd0, 32'd0);
    smp();
    checkOutput("t2_exu_rdy", 32'(exu_wbck_rdy), 32'd1);
    cyc();
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    smp();
    cyc();
    smp();
    checkOutput("t2_wr_vld_empty", 32'(wr_vld), 32'd0);
    cyc();

    // Output hold with wr_rdy low, then no-bubble reload
    wr_rdy = 1'b0;
    applyStimulus(2, 1'b1, 5'd9, 32'h99);
    push_exp(5'd9, 32'h99);
    smp();
    checkOutput("t3_mdu_rdy_first", 32'(mdu_wbck_rdy), 32'd1);
    cyc();
    applyStimulus(2, 1'b1, 5'd10, 32'h1010);
    push_exp(5'd10, 32'h1010);
    for (int i = 0; i < 3; i++) begin
      smp();
      checkOutput("t3_hold_wr_vld", 32'(wr_vld), 32'd1);
      checkOutput("t3_hold_wr_idx", {27'd0, wr_idx}, 32'd9);
      checkOutput("t3_hold_wr_data", wr_data, 32'h99);
      checkOutput("t3_hold_rdys", {29'd0, exu_wbck_rdy, lsu_wbck_rdy, mdu_wbck_rdy}, 32'd0);
      cyc();
    end
    wr_rdy = 1'b1;
    smp();
    checkOutput("t3_mdu_rdy_nobubble", 32'(mdu_wbck_rdy), 32'd1);
    cyc();
    applyStimulus(2, 1'b0, 5'd0, 32'd0);
    smp();
    checkOutput("t3_wr_vld_b2b", 32'(wr_vld), 32'd1);
    checkOutput("t3_wr_idx_b2b", {27'd0, wr_idx}, 32'd10);
    cyc();
    smp();
    checkOutput("t3_wr_vld_empty", 32'(wr_vld), 32'd0);
    cyc();

    // Starvation: EXU promoted on the 5th cycle
    applyStimulus(2, 1'b1, 5'd6, 32'h66);
    applyStimulus(0, 1'b1, 5'd2, 32'hE0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 5'd1, 32'hA0 + 32'(i));
      if (i < 4) push_exp(5'd1, 32'hA0 + 32'(i));
      else       push_exp(5'd2, 32'hE0);
      smp();
      checkOutput("t4_lsu_rdy", 32'(lsu_wbck_rdy), (i < 4) ? 32'd1 : 32'd0);
      checkOutput("t4_exu_rdy", 32'(exu_wbck_rdy), (i == 4) ? 32'd1 : 32'd0);
      checkOutput("t4_mdu_rdy", 32'(mdu_wbck_rdy), 32'd0);
      cyc();
    end
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    applyStimulus(1, 1'b0, 5'd0, 32'd0);
    applyStimulus(2, 1'b0, 5'd0, 32'd0);
    smp();
    cyc();
    // Counter cleared: LSU wins again over EXU
    applyStimulus(1, 1'b1, 5'd1, 32'hB0);
    applyStimulus(0, 1'b1, 5'd2, 32'hE1);
    push_exp(5'd1, 32'hB0);
    push_exp(5'd2, 32'hE1);
    smp();
    checkOutput("t4_post_lsu_rdy", 32'(lsu_wbck_rdy), 32'd1);
    checkOutput("t4_post_exu_rdy", 32'(exu_wbck_rdy), 32'd0);
    cyc();
    applyStimulus(1, 1'b0, 5'd0, 32'd0);
    smp();
    checkOutput("t4_post_exu_gnt", 32'(exu_wbck_rdy), 32'd1);
    cyc();
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    smp();
    cyc();
    smp();
    cyc();

    // x0 writes are accepted but never reach the register file
    applyStimulus(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    smp();
    checkOutput("t5_exu_rdy_x0", 32'(exu_wbck_rdy), 32'd1);
    cyc();
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    smp();
    checkOutput("t5_wr_vld_x0", 32'(wr_vld), 32'd0);
    cyc();
    applyStimulus(2, 1'b1, 5'd12, 32'hC0C0);
    push_exp(5'd12, 32'hC0C0);
    smp();
    cyc();
    applyStimulus(2, 1'b0, 5'd0, 32'd0);
    applyStimulus(0, 1'b1, 5'd0, 32'hDEAD);
    smp();
    checkOutput("t5_exu_rdy_x0_drain", 32'(exu_wbck_rdy), 32'd1);
    cyc();
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    smp();
    checkOutput("t5_wr_vld_after_x0_drain", 32'(wr_vld), 32'd0);
    cyc();

    // Forwarding from a held entry, then reset discards it
    wr_rdy = 1'b0;
    applyStimulus(0, 1'b1, 5'd7, 32'h1234);
    push_exp(5'd7, 32'h1234);
    smp();
    cyc();
    applyStimulus(0, 1'b0, 5'd0, 32'd0);
    rs1_idx = 5'd7;
    rs2_idx = 5'd0;
    smp();
    checkOutput("t6_fwd_rs1_hit", 32'(fwd_rs1_hit), FWD ? 32'd1 : 32'd0);
    checkOutput("t6_fwd_rs2_hit", 32'(fwd_rs2_hit), 32'd0);
    checkOutput("t6_fwd_data", fwd_data, FWD ? 32'h1234 : 32'd0);
    #1;
    rs1_idx = 5'd8;
    #1;
    checkOutput("t6_fwd_rs1_miss", 32'(fwd_rs1_hit), 32'd0);
    rs1_idx = 5'd7;
    cyc();
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("t7_rst_wr_vld", 32'(wr_vld), 32'd0);
    checkOutput("t7_rst_wr_idx", {27'd0, wr_idx}, 32'd0);
    checkOutput("t7_rst_wr_data", wr_data, 32'd0);
    checkOutput("t7_rst_fwd_rs1_hit", 32'(fwd_rs1_hit), 32'd0);
    #2;
    reset_n = 1'b1;
    wr_rdy  = 1'b1;
    cyc();
    smp();
    checkOutput("t7_wr_vld_after_rst", 32'(wr_vld), 32'd0);
    cyc();
    cyc();
    checkOutput("sb_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lnrv_wbck.md
Name: lnrv_wbck

Overview:
- Write-back arbiter and pipeline stage that sits directly upstream of the general-purpose register file write port.
- Collects results from three producers: EXU (single-cycle ALU/branch), LSU (load data) and MDU (multiply/divide).
- Selects one result per cycle, registers it in a one-entry output stage, and drives the register file write handshake.
- Writes to x0 are absorbed and never presented to the register file.

Parameters:
- P_STARVE_LIMIT, 4, consecutive EXU-blocked cycles before EXU is promoted to top priority; 0 disables promotion; legal range 0..15.
- P_DATA_WIDTH, 32, result/write data width.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- exu_wbck_vld  input  1  EXU result valid
- exu_wbck_rdy  output  1  EXU result accepted this cycle when high with vld
- exu_wbck_idx  input  5  EXU destination register
- exu_wbck_data  input  32  EXU result
- lsu_wbck_vld/rdy/idx/data  in/out/in/in  1/1/5/32  LSU result channel, same semantics
- mdu_wbck_vld/rdy/idx/data  in/out/in/in  1/1/5/32  MDU result channel, same semantics
- wr_vld  output  1  register file write valid
- wr_rdy  input  1  register file write ready
- wr_idx  output  5  register file write index
- wr_data  output  32  register file write data
- rs1_idx, rs2_idx  input  5 each  read indices from decode (forwarding lookup)
- fwd_rs1_hit, fwd_rs2_hit  output  1 each  pending output entry matches rsN_idx
- fwd_data  output  32  data of pending output entry

Behaviour:
- Reset (async, reset_n low): output stage empty; wr_vld=0, wr_idx=0, wr_data=0; starvation counter=0; fwd hits=0. Reset mid-transfer discards the held entry.
- Transfer on any channel occurs when vld&rdy are both high at a rising clk edge. Producers hold vld/idx/data stable until accepted.
- Output stage load enable: load_ok = ~occ | (wr_vld & wr_rdy), so back-to-back writes run at one per cycle.
- Arbitration when load_ok:
  - Default fixed priority LSU > MDU > EXU.
  - If starve_cnt == P_STARVE_LIMIT (and limit != 0), EXU takes top priority, then LSU > MDU.
  - Exactly one rdy is high, and only for the granted channel with vld high. All rdy are 0 when ~load_ok.
- Latency: the result accepted at edge N appears on wr_vld/wr_idx/wr_data from N until the edge at which wr_rdy is high.
- x0 handling: a granted result with idx==0 is accepted (rdy high) but not loaded. The output becomes empty if it drained the same cycle, otherwise it is unchanged.
- Starvation counter:
  - Increments (saturating at P_STARVE_LIMIT) each cycle exu_wbck_vld is high and EXU is not granted.
  - Clears on EXU grant or when exu_wbck_vld is low.
- Output hold: while wr_vld & ~wr_rdy, wr_idx and wr_data are stable and no channel is granted.
- Simultaneous drain and load: the new entry replaces the old at the same edge and wr_vld stays 1.

Optional Feature:
- LNRV_WBCK_FWD_EN defined:
  - fwd_rsN_hit = occ & (wr_idx == rsN_idx) & (rsN_idx != 0).
  - fwd_data = wr_data.
  - Purely combinational from the output register.
- Not defined: fwd_rs1_hit = fwd_rs2_hit = 0 and fwd_data = 0. Ports remain so the interface is identical.

Test Plan:
- EXU idx=5 data=0x11 alone, wr_rdy=1 -> exu_rdy high in cycle 0; wr_vld=1, wr_idx=5, wr_data=0x11 in cycle 1; wr_vld=0 in cycle 2.
- LSU (idx 3, 0xAA) and EXU (idx 4, 0xBB) valid in the same cycle, wr_rdy=1 -> LSU granted first; EXU one cycle later; writes appear in order 3 then 4.
- wr_rdy=0 for 3 cycles with an entry held -> wr_idx/wr_data unchanged and all channel rdy=0; on wr_rdy=1, the next pending result loads the same edge with no bubble.
- LSU+MDU continuously valid and EXU valid, P_STARVE_LIMIT=4, wr_rdy=1 -> EXU granted on the 5th cycle; counter returns to 0.
- EXU idx=0 data=0xFFFF_FFFF -> exu_rdy=1; wr_vld stays 0; no write reaches the register file.
- With LNRV_WBCK_FWD_EN, held entry idx 7 data 0x1234, rs1_idx=7, rs2_idx=0 -> fwd_rs1_hit=1, fwd_rs2_hit=0, fwd_data=0x1234. Without the macro, both hits are 0.
